// File: rtl/div_approx_pkg.sv
// Shared types for the sequential approximate-row divider: FSM states and row cell modes.
package div_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    CELL_EXACT  = 1'b0,
    CELL_APPROX = 1'b1
  } cell_mode_t;

endpackage

// File: rtl/div_row_cell.sv
// One subtractor cell of the shared divider row, selectable between exact and approximate borrow logic.
module div_row_cell
  import div_approx_pkg::*;
(
  input  logic       x_i,
  input  logic       y_i,
  input  logic       bin_i,
  input  cell_mode_t mode_i,
  output logic       diff_o,
  output logic       bout_o
);

  always_comb begin
    diff_o = x_i ^ y_i ^ bin_i;
    bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
    // Approximate cell drops the borrow input entirely, cutting the ripple chain.
    if (mode_i == CELL_APPROX) begin
      diff_o = x_i;
      bout_o = ~x_i & ~y_i;
    end
  end

endmodule

// File: rtl/divider_seq_approx_row.sv
// Iterative restoring divider (2W / W) retiring one quotient bit per cycle through a single reusable
// row of W subtractor cells; the lowest APPROX_ROWS iterations may run on approximate cells.
module divider_seq_approx_row
  import div_approx_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           div_zero,
  output logic           ovf
);

  localparam int KW = $clog2(W);
  localparam int AR = (APPROX_ROWS > W) ? W : APPROX_ROWS;

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  low_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  quo_q;
  logic          ae_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          dz_q;
  logic          ovf_q;

  logic [W-1:0]  win;
  logic [W-1:0]  diff;
  logic [W:0]    borrow;
  logic          top_bit;
  logic          qbit;
  cell_mode_t    mode;

  // Shifted window of the partial remainder; the bit shifted out (top_bit) forces a subtract.
  assign win     = {rem_q[W-2:0], low_q[k_q]};
  assign top_bit = rem_q[W-1];
  assign mode    = (ae_q && (int'(k_q) < AR)) ? CELL_APPROX : CELL_EXACT;

  assign borrow[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_row
    div_row_cell u_cell (
      .x_i    (win[i]),
      .y_i    (dvs_q[i]),
      .bin_i  (borrow[i]),
      .mode_i (mode),
      .diff_o (diff[i]),
      .bout_o (borrow[i+1])
    );
  end

  assign qbit  = top_bit | ~borrow[W];
  assign rem_d = qbit ? diff : win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            low_q      <= n[W-1:0];
            rem_q      <= n[2*W-1:W];
            dvs_q      <= d;
            ae_q       <= approx_en;
            dz_q       <= (d == '0);
            ovf_q      <= (n[2*W-1:W] >= d);
            k_q        <= KW'(W - 1);
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          quo_q[k_q] <= qbit;
          rem_q      <= rem_d;
          if (k_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = quo_q;
  assign r         = rem_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule
